// File: rtl/pe_pkg.sv
// -----------------------------------------------------------------------------
// pe_pkg
// Shared definitions for the priority-encoder request front end.
//   CODE_*     : 2-bit codes produced by the PE ({o2,o1}); CODE_NONE = no request
//   NUM_REQ    : number of request lines feeding the PE
//   state_t    : handshake FSM states of pe_req_latch
//   code_to_onehot : maps a serviced code back to the pending bit it clears
// -----------------------------------------------------------------------------
package pe_pkg;

  localparam logic [1:0] CODE_NONE = 2'd0;
  localparam logic [1:0] CODE_Q1   = 2'd1;
  localparam logic [1:0] CODE_Q2   = 2'd2;
  localparam logic [1:0] CODE_Q3   = 2'd3;

  localparam int NUM_REQ = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // Code 1..3 selects pending bit 0..2; CODE_NONE selects nothing.
  function automatic logic [NUM_REQ-1:0] code_to_onehot(input logic [1:0] code);
    logic [NUM_REQ-1:0] onehot;
    onehot = '0;
    case (code)
      CODE_Q1: onehot = 3'b001;
      CODE_Q2: onehot = 3'b010;
      CODE_Q3: onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
    return onehot;
  endfunction

endpackage

// File: rtl/pe_req_sync.sv
// -----------------------------------------------------------------------------
// pe_req_sync
// Brings one asynchronous request line into the clock domain and turns it into
// a registered capture pulse.
//   clock     in  : sole clock, rising edge
//   reset_n   in  : asynchronous active-low reset
//   raw_req   in  : asynchronous request line
//   capture   out : EDGE_MODE=1 -> one-cycle pulse per synced rising edge
//                   EDGE_MODE=0 -> high every cycle the synced level is high
// Latency: a rise first sampled at edge k gives capture=1 during the cycle
// after edge k+SYNC_STAGES, so the consumer registers it at edge k+SYNC_STAGES+1.
// SYNC_STAGES must lie in 2..4.
// -----------------------------------------------------------------------------
module pe_req_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_MODE   = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw_req,
  output logic capture
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   synced_d_reg;
  logic [SYNC_STAGES:0]   fill_reg;
  logic                   capture_reg;
  logic                   capture_next;

  // fill_reg tracks which pipeline flops hold a genuine sample since reset.
  // Without it, a line already high across reset release would look like a
  // fresh rising edge (the edge flop resets to 0), producing a bogus capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg     <= '0;
      synced_d_reg <= 1'b0;
      fill_reg     <= '0;
      capture_reg  <= 1'b0;
    end else begin
      sync_reg     <= {sync_reg[SYNC_STAGES-2:0], raw_req};
      synced_d_reg <= sync_reg[SYNC_STAGES-1];
      fill_reg     <= {fill_reg[SYNC_STAGES-1:0], 1'b1};
      capture_reg  <= capture_next;
    end
  end

  always_comb begin
    capture_next = 1'b0;
    if (EDGE_MODE) begin
      capture_next = fill_reg[SYNC_STAGES] & sync_reg[SYNC_STAGES-1] & ~synced_d_reg;
    end else begin
      capture_next = sync_reg[SYNC_STAGES-1];
    end
  end

  assign capture = capture_reg;

endmodule

// File: rtl/pe_req_latch.sv
// -----------------------------------------------------------------------------
// pe_req_latch
// Front end of the 3-input priority encoder (PE). Synchronises three async
// request lines, keeps each as a sticky pending bit driven onto the PE inputs,
// registers the PE's code and offers it downstream on valid/ready. Acceptance
// clears only the pending bit that was serviced.
//   clock        in  1 : sole clock, rising edge
//   reset_n      in  1 : asynchronous active-low reset
//   raw_req      in  3 : async requests; bit0->q1, bit1->q2, bit2->q3
//   q1,q2,q3     out 1 : registered pending bits to the PE
//   enc_code     in  2 : {o2,o1} from the PE, combinational from q1..q3
//   out_valid    out 1 : out_code is valid
//   out_ready    in  1 : downstream accepts out_code this cycle
//   out_code     out 2 : 3=q3, 2=q2, 1=q1; never 0 while out_valid
//   overrun      out 3 : sticky, a capture hit an already-pending bit
//   clr_overrun  in  1 : synchronous clear of all overrun bits
// -----------------------------------------------------------------------------
module pe_req_latch
  import pe_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_MODE   = 1'b1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [2:0]   raw_req,
  output logic         q1,
  output logic         q2,
  output logic         q3,
  input  logic [1:0]   enc_code,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   out_code,
  output logic [2:0]   overrun,
  input  logic         clr_overrun
);

  logic [NUM_REQ-1:0] capture;
  logic [NUM_REQ-1:0] pending_reg;
  logic [NUM_REQ-1:0] pending_next;
  logic [NUM_REQ-1:0] overrun_reg;
  logic [NUM_REQ-1:0] overrun_next;
  logic [NUM_REQ-1:0] overrun_set;
  logic [NUM_REQ-1:0] service_clr;
  logic [1:0]         out_code_reg;
  logic [1:0]         out_code_next;
  state_t             state_reg;
  state_t             state_next;

  // One synchroniser/edge detector per request line.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_sync
      pe_req_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_MODE   (EDGE_MODE)
      ) u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .raw_req (raw_req[gi]),
        .capture (capture[gi])
      );
    end
  endgenerate

  // Handshake FSM. out_code is loaded only on the IDLE->OFFER transition, so a
  // higher-priority request arriving mid-offer cannot disturb the offered code.
  always_comb begin
    state_next    = state_reg;
    out_code_next = out_code_reg;
    service_clr   = '0;
    case (state_reg)
      IDLE: begin
        // enc_code==0 with pending bits set means the PE misbehaved; waiting
        // in IDLE is the only safe response since there is no code to offer.
        if (enc_code != CODE_NONE) begin
          out_code_next = enc_code;
          state_next    = OFFER;
        end
      end
      OFFER: begin
        if (out_ready) begin
          service_clr = code_to_onehot(out_code_reg);
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture is ORed in after the clear, so a capture landing on the accept
  // cycle of the same bit keeps it pending.
  always_comb begin
    pending_next = (pending_reg & ~service_clr) | capture;
  end

  // Level mode re-captures every cycle the line is high, so a repeat capture
  // there is expected and never reported. A simultaneous service clear turns
  // the capture into a fresh request rather than an overrun.
  always_comb begin
    overrun_set = '0;
    if (EDGE_MODE) begin
      overrun_set = capture & pending_reg & ~service_clr;
    end
    overrun_next = (overrun_reg & ~{NUM_REQ{clr_overrun}}) | overrun_set;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      out_code_reg <= CODE_NONE;
      pending_reg  <= '0;
      overrun_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      out_code_reg <= out_code_next;
      pending_reg  <= pending_next;
      overrun_reg  <= overrun_next;
    end
  end

  assign q1        = pending_reg[0];
  assign q2        = pending_reg[1];
  assign q3        = pending_reg[2];
  assign out_valid = (state_reg == OFFER);
  assign out_code  = out_code_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_pe_req_latch.sv
// -----------------------------------------------------------------------------
// tb_pe_req_latch
// Directed bench for pe_req_latch (SYNC_STAGES=2, EDGE_MODE=1) with a
// behavioural PE closing the loop from q1..q3 back to enc_code.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point too.
// -----------------------------------------------------------------------------
module tb_pe_req_latch;

  logic       clock;
  logic       reset_n;
  logic [2:0] raw_req;
  logic       q1, q2, q3;
  logic [1:0] enc_code;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_code;
  logic [2:0] overrun;
  logic       clr_overrun;

  int errors = 0;
  int checks = 0;

  pe_req_latch #(
    .SYNC_STAGES (2),
    .EDGE_MODE   (1'b1)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .raw_req     (raw_req),
    .q1          (q1),
    .q2          (q2),
    .q3          (q3),
    .enc_code    (enc_code),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_code    (out_code),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  // The PE in the loop: q3 > q2 > q1.
  assign enc_code = q3 ? 2'd3 : (q2 ? 2'd2 : (q1 ? 2'd1 : 2'd0));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [1:0] exp_order [3];

  initial begin
    exp_order[0] = 2'd2;
    exp_order[1] = 2'd3;
    exp_order[2] = 2'd1;

    // 1: reset with all requests high, then release with no edge
    reset_n     = 1'b0;
    raw_req     = 3'b111;
    out_ready   = 1'b0;
    clr_overrun = 1'b0;
    step(3);
    chk("rst_q",       {q3, q2, q1},        3'b000);
    chk("rst_valid",   {2'b00, out_valid},  3'd0);
    chk("rst_code",    {1'b0, out_code},    3'd0);
    chk("rst_overrun", overrun,             3'b000);
    reset_n = 1'b1;
    step(6);
    chk("rel_q",       {q3, q2, q1},        3'b000);
    chk("rel_valid",   {2'b00, out_valid},  3'd0);

    // 2: single request, latency check
    raw_req = 3'b000;
    step(5);
    raw_req   = 3'b001;
    out_ready = 1'b1;
    step(1);                              // edge 0
    step(2);                              // edge 2
    chk("lat_q1_e2",   {2'b00, q1},         3'd0);
    step(1);                              // edge 3
    chk("lat_q1_e3",   {2'b00, q1},         3'd1);
    chk("lat_vld_e3",  {2'b00, out_valid},  3'd0);
    step(1);                              // edge 4
    chk("lat_vld_e4",  {2'b00, out_valid},  3'd1);
    chk("lat_code_e4", {1'b0, out_code},    3'd1);
    step(1);                              // edge 5
    chk("lat_q1_e5",   {2'b00, q1},         3'd0);
    chk("lat_vld_e5",  {2'b00, out_valid},  3'd0);
    step(2);
    chk("idle_vld",    {2'b00, out_valid},  3'd0);

    // 3: priority and hold, then ordered drain
    out_ready = 1'b0;
    raw_req   = 3'b000;
    step(5);
    raw_req = 3'b011;
    step(4);
    chk("pri_q",       {q3, q2, q1},        3'b011);
    step(1);
    chk("pri_code",    {1'b0, out_code},    3'd2);
    for (int i = 0; i < 10; i++) begin
      if (i == 2) raw_req[2] = 1'b1;
      if (i == 5) raw_req[2] = 1'b0;
      step(1);
      chk("hold_code",  {1'b0, out_code},   3'd2);
      chk("hold_valid", {2'b00, out_valid}, 3'd1);
    end
    chk("hold_q",      {q3, q2, q1},        3'b111);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("ord_valid", {2'b00, out_valid},  3'd1);
      chk("ord_code",  {1'b0, out_code},    {1'b0, exp_order[i]});
      step(1);
      chk("ord_drop",  {2'b00, out_valid},  3'd0);
      step(1);
    end
    out_ready = 1'b0;
    chk("ord_empty",   {q3, q2, q1},        3'b000);
    chk("ord_nvalid",  {2'b00, out_valid},  3'd0);
    chk("ord_overrun", overrun,             3'b000);

    // 4: overrun on q1, then clear
    raw_req = 3'b010;
    step(5);
    raw_req = 3'b011;
    step(5);
    chk("ovr_code1",   {1'b0, out_code},    3'd1);
    chk("ovr_pre",     overrun,             3'b000);
    raw_req = 3'b010;
    step(4);
    raw_req = 3'b011;
    step(4);
    chk("ovr_set",     overrun,             3'b001);
    chk("ovr_q",       {q3, q2, q1},        3'b001);
    clr_overrun = 1'b1;
    step(1);
    clr_overrun = 1'b0;
    chk("ovr_clr",     overrun,             3'b000);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    chk("ovr_drain",   {q3, q2, q1},        3'b000);
    step(2);

    // 5: capture of q2 landing on the accept cycle of code 2
    raw_req = 3'b001;
    step(5);
    raw_req = 3'b011;
    step(5);
    chk("col_code",    {1'b0, out_code},    3'd2);
    raw_req = 3'b001;
    step(5);
    raw_req = 3'b011;
    step(3);                              // edges k, k+1, k+2
    out_ready = 1'b1;
    step(1);                              // edge k+3: accept and capture
    out_ready = 1'b0;
    chk("col_q2",      {2'b00, q2},         3'd1);
    chk("col_overrun", overrun,             3'b000);
    chk("col_drop",    {2'b00, out_valid},  3'd0);
    step(1);
    chk("col_revalid", {2'b00, out_valid},  3'd1);
    chk("col_recode",  {1'b0, out_code},    3'd2);

    // 6: asynchronous reset mid-offer
    raw_req = 3'b001;
    step(5);
    raw_req = 3'b011;
    step(4);
    chk("ar_pre_ovr",  overrun,             3'b010);
    chk("ar_pre_vld",  {2'b00, out_valid},  3'd1);
    #2;
    reset_n = 1'b0;
    #1;                                   // still before the next rising edge
    chk("ar_valid",    {2'b00, out_valid},  3'd0);
    chk("ar_q",        {q3, q2, q1},        3'b000);
    chk("ar_overrun",  overrun,             3'b000);
    chk("ar_code",     {1'b0, out_code},    3'd0);
    step(2);
    reset_n = 1'b1;
    step(6);
    chk("ar_norep_q",  {q3, q2, q1},        3'b000);
    chk("ar_norep_v",  {2'b00, out_valid},  3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
